// File: rtl/imm_enc_if.sv
// imm_enc_if: request/response bundle for the constant-load encoder.
//   Request : in_valid, in_ready, in_value[31:0], in_rt[4:0]
//   Response: out_valid, out_ready, out_instr[31:0], out_eop[1:0], out_last
//   modport master - request producer and instruction consumer
//   modport slave  - the encoder
interface imm_enc_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_value;
  logic [4:0]  in_rt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [1:0]  out_eop;
  logic        out_last;

  modport master (
    output in_valid, in_value, in_rt, out_ready,
    input  in_ready, out_valid, out_instr, out_eop, out_last
  );

  modport slave (
    input  in_valid, in_value, in_rt, out_ready,
    output in_ready, out_valid, out_instr, out_eop, out_last
  );
endinterface

// File: rtl/imm_enc.sv
// imm_enc: turns a 32-bit constant plus destination register into the shortest
// MIPS load sequence (addiu / ori / lui, or lui+ori for a full 32-bit value).
//   clk, rst_n  - clock, asynchronous active-low reset
//   bus (slave) - request in (in_valid/in_ready/in_value/in_rt),
//                 words out (out_valid/out_ready/out_instr/out_eop/out_last)
//   USE_ADDIU   - nonzero allows the sign-extended addiu form
// Optional macro IMM_ENC_STATS_EN adds stat_words / stat_pairs counters.
module imm_enc #(
  parameter int unsigned USE_ADDIU = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  imm_enc_if.slave   bus
`ifdef IMM_ENC_STATS_EN
  ,
  output logic [15:0] stat_words,
  output logic [15:0] stat_pairs
`endif
);

  localparam int unsigned IW = 16;
  localparam int unsigned RW = 5;
  localparam int unsigned OW = 6;
  localparam int unsigned SW = 16;

  localparam logic [OW-1:0] OP_ADDIU = 6'b001001;
  localparam logic [OW-1:0] OP_ORI   = 6'b001101;
  localparam logic [OW-1:0] OP_LUI   = 6'b001111;

  localparam logic [1:0] EOP_SIGN  = 2'b00;
  localparam logic [1:0] EOP_ZERO  = 2'b01;
  localparam logic [1:0] EOP_UPPER = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WORD1 = 2'd1,
    S_WORD2 = 2'd2
  } state_t;

  state_t        state_q, state_nxt;

  logic          in_ready_q;
  logic          out_valid_q, out_valid_nxt;
  logic [31:0]   out_instr_q, out_instr_nxt;
  logic [1:0]    out_eop_q,   out_eop_nxt;
  logic          out_last_q,  out_last_nxt;
  logic [IW-1:0] lo_q, lo_nxt;
  logic [RW-1:0] rt_q, rt_nxt;

  logic          accept_c;
  logic          hs_c;

  logic [IW-1:0] hi_c;
  logic [IW-1:0] lo_c;
  logic          sext_ok_c;
  logic          zext_ok_c;
  logic          upper_ok_c;
  logic [31:0]   cls_instr_c;
  logic [1:0]    cls_eop_c;
  logic          cls_single_c;

  assign accept_c = bus.in_valid && in_ready_q;
  assign hs_c     = out_valid_q && bus.out_ready;

  // Classify the incoming constant; first word and whether a second follows.
  always_comb begin
    hi_c         = bus.in_value[31:16];
    lo_c         = bus.in_value[15:0];
    sext_ok_c    = (USE_ADDIU != 0) &&
                   ((&bus.in_value[31:15]) || !(|bus.in_value[31:15]));
    zext_ok_c    = !(|hi_c);
    upper_ok_c   = !(|lo_c);
    cls_instr_c  = {OP_LUI, 5'd0, bus.in_rt, hi_c};
    cls_eop_c    = EOP_UPPER;
    cls_single_c = 1'b0;
    if (sext_ok_c) begin
      cls_instr_c  = {OP_ADDIU, 5'd0, bus.in_rt, lo_c};
      cls_eop_c    = EOP_SIGN;
      cls_single_c = 1'b1;
    end else if (zext_ok_c) begin
      cls_instr_c  = {OP_ORI, 5'd0, bus.in_rt, lo_c};
      cls_eop_c    = EOP_ZERO;
      cls_single_c = 1'b1;
    end else if (upper_ok_c) begin
      cls_single_c = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state logic; a single-word request carries out_last on word 1.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE:  if (accept_c) state_nxt = S_WORD1;
      S_WORD1: if (hs_c)     state_nxt = out_last_q ? S_IDLE : S_WORD2;
      S_WORD2: if (hs_c)     state_nxt = S_IDLE;
      default:               state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and captured request fields.
  always_comb begin
    out_valid_nxt = out_valid_q;
    out_instr_nxt = out_instr_q;
    out_eop_nxt   = out_eop_q;
    out_last_nxt  = out_last_q;
    lo_nxt        = lo_q;
    rt_nxt        = rt_q;
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          out_valid_nxt = 1'b1;
          out_instr_nxt = cls_instr_c;
          out_eop_nxt   = cls_eop_c;
          out_last_nxt  = cls_single_c;
          lo_nxt        = lo_c;
          rt_nxt        = bus.in_rt;
        end
      end
      S_WORD1: begin
        if (hs_c) begin
          if (out_last_q) begin
            out_valid_nxt = 1'b0;
            out_last_nxt  = 1'b0;
          end else begin
            // Second word ORs the low half into the register lui just set.
            out_instr_nxt = {OP_ORI, rt_q, rt_q, lo_q};
            out_eop_nxt   = EOP_ZERO;
            out_last_nxt  = 1'b1;
          end
        end
      end
      S_WORD2: begin
        if (hs_c) begin
          out_valid_nxt = 1'b0;
          out_last_nxt  = 1'b0;
        end
      end
      default: begin
        out_valid_nxt = 1'b0;
        out_last_nxt  = 1'b0;
      end
    endcase
  end

  // Output and capture registers; in_ready mirrors the upcoming IDLE state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_instr_q <= 32'd0;
      out_eop_q   <= EOP_SIGN;
      out_last_q  <= 1'b0;
      lo_q        <= '0;
      rt_q        <= '0;
    end else begin
      in_ready_q  <= (state_nxt == S_IDLE);
      out_valid_q <= out_valid_nxt;
      out_instr_q <= out_instr_nxt;
      out_eop_q   <= out_eop_nxt;
      out_last_q  <= out_last_nxt;
      lo_q        <= lo_nxt;
      rt_q        <= rt_nxt;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_eop   = out_eop_q;
  assign bus.out_last  = out_last_q;

`ifdef IMM_ENC_STATS_EN
  logic [SW-1:0] stat_words_q;
  logic [SW-1:0] stat_pairs_q;

  // Handshake counters; wrap naturally at 2^16.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_words_q <= '0;
      stat_pairs_q <= '0;
    end else begin
      if (hs_c) begin
        stat_words_q <= SW'(stat_words_q + SW'(1));
      end
      if (hs_c && (state_q == S_WORD2)) begin
        stat_pairs_q <= SW'(stat_pairs_q + SW'(1));
      end
    end
  end

  assign stat_words = stat_words_q;
  assign stat_pairs = stat_pairs_q;
`endif

endmodule

// File: tb/tb_imm_enc.sv
// tb_imm_enc: directed bench for imm_enc. Instance u0 uses USE_ADDIU=1,
// instance u1 uses USE_ADDIU=0; both share in_value/in_rt/out_ready.
module tb_imm_enc;

  logic clk;
  logic rst_n;

  imm_enc_if b0 ();
  imm_enc_if b1 ();

`ifdef IMM_ENC_STATS_EN
  logic [15:0] sw0, sp0, sw1, sp1;
  imm_enc #(.USE_ADDIU(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0),
                               .stat_words(sw0), .stat_pairs(sp0));
  imm_enc #(.USE_ADDIU(0)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1),
                               .stat_words(sw1), .stat_pairs(sp1));
`else
  imm_enc #(.USE_ADDIU(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  imm_enc #(.USE_ADDIU(0)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sel;
    logic [31:0] value;
    logic [4:0]  rt;
    int          nwords;
    logic [31:0] w1;
    logic [1:0]  e1;
    logic [31:0] w2;
    logic [1:0]  e2;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  int n_checks;
  int n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic sample(input logic sel, output logic v, output logic [31:0] ins,
                        output logic [1:0] e, output logic l, output logic r);
    if (sel) begin
      v = b1.out_valid; ins = b1.out_instr; e = b1.out_eop; l = b1.out_last; r = b1.in_ready;
    end else begin
      v = b0.out_valid; ins = b0.out_instr; e = b0.out_eop; l = b0.out_last; r = b0.in_ready;
    end
  endtask

  task automatic drive_req(input logic sel, input logic [31:0] value, input logic [4:0] rt);
    @(negedge clk);
    b0.in_value = value;
    b1.in_value = value;
    b0.in_rt    = rt;
    b1.in_rt    = rt;
    b0.in_valid = !sel;
    b1.in_valid = sel;
    @(posedge clk);
    #1;
    b0.in_valid = 1'b0;
    b1.in_valid = 1'b0;
  endtask

  task automatic run_vec(input int idx);
    logic v, l, r;
    logic [31:0] ins;
    logic [1:0] e;
    vec_t t;
    t = vecs[idx];
    b0.out_ready = 1'b1;
    b1.out_ready = 1'b1;
    drive_req(t.sel, t.value, t.rt);
    sample(t.sel, v, ins, e, l, r);
    check($sformatf("v%0d_w1_valid", idx), 32'(v), 32'd1);
    check($sformatf("v%0d_w1_instr", idx), ins, t.w1);
    check($sformatf("v%0d_w1_eop", idx), 32'(e), 32'(t.e1));
    check($sformatf("v%0d_w1_last", idx), 32'(l), (t.nwords == 1) ? 32'd1 : 32'd0);
    check($sformatf("v%0d_w1_inready", idx), 32'(r), 32'd0);
    if (t.nwords == 2) begin
      @(posedge clk);
      #1;
      sample(t.sel, v, ins, e, l, r);
      check($sformatf("v%0d_w2_valid", idx), 32'(v), 32'd1);
      check($sformatf("v%0d_w2_instr", idx), ins, t.w2);
      check($sformatf("v%0d_w2_eop", idx), 32'(e), 32'(t.e2));
      check($sformatf("v%0d_w2_last", idx), 32'(l), 32'd1);
    end
    @(posedge clk);
    #1;
    sample(t.sel, v, ins, e, l, r);
    check($sformatf("v%0d_done_valid", idx), 32'(v), 32'd0);
    check($sformatf("v%0d_done_inready", idx), 32'(r), 32'd1);
  endtask

  initial begin
    logic v, l, r;
    logic [31:0] ins;
    logic [1:0] e;

    n_checks = 0;
    n_fail   = 0;

    //            sel   value          rt     n  w1             e1     w2             e2
    vecs[0]  = '{1'b0, 32'hFFFF_FFFF, 5'd8,  1, 32'h2408_FFFF, 2'b00, 32'h0,         2'b00};
    vecs[1]  = '{1'b0, 32'h0000_8000, 5'd9,  1, 32'h3409_8000, 2'b01, 32'h0,         2'b00};
    vecs[2]  = '{1'b0, 32'h1234_0000, 5'd10, 1, 32'h3C0A_1234, 2'b10, 32'h0,         2'b00};
    vecs[3]  = '{1'b0, 32'h1234_5678, 5'd8,  2, 32'h3C08_1234, 2'b10, 32'h3508_5678, 2'b01};
    vecs[4]  = '{1'b0, 32'h0000_7FFF, 5'd0,  1, 32'h2400_7FFF, 2'b00, 32'h0,         2'b00};
    vecs[5]  = '{1'b0, 32'h0000_0000, 5'd3,  1, 32'h2403_0000, 2'b00, 32'h0,         2'b00};
    vecs[6]  = '{1'b0, 32'hFFFF_8000, 5'd31, 1, 32'h241F_8000, 2'b00, 32'h0,         2'b00};
    vecs[7]  = '{1'b0, 32'h0000_FFFF, 5'd5,  1, 32'h3405_FFFF, 2'b01, 32'h0,         2'b00};
    vecs[8]  = '{1'b0, 32'h8000_0000, 5'd1,  1, 32'h3C01_8000, 2'b10, 32'h0,         2'b00};
    vecs[9]  = '{1'b0, 32'h0001_0001, 5'd2,  2, 32'h3C02_0001, 2'b10, 32'h3442_0001, 2'b01};
    vecs[10] = '{1'b1, 32'hFFFF_FFFF, 5'd8,  2, 32'h3C08_FFFF, 2'b10, 32'h3508_FFFF, 2'b01};
    vecs[11] = '{1'b1, 32'h0000_0000, 5'd3,  1, 32'h3403_0000, 2'b01, 32'h0,         2'b00};
    vecs[12] = '{1'b1, 32'h0000_7FFF, 5'd0,  1, 32'h3400_7FFF, 2'b01, 32'h0,         2'b00};

    b0.in_valid = 1'b0; b1.in_valid = 1'b0;
    b0.in_value = 32'd0; b1.in_value = 32'd0;
    b0.in_rt = 5'd0; b1.in_rt = 5'd0;
    b0.out_ready = 1'b0; b1.out_ready = 1'b0;

    // Reset state.
    rst_n = 1'b0;
    #3;
    check("rst_valid", 32'(b0.out_valid), 32'd0);
    check("rst_instr", b0.out_instr, 32'd0);
    check("rst_eop", 32'(b0.out_eop), 32'd0);
    check("rst_last", 32'(b0.out_last), 32'd0);
    check("rst_inready", 32'(b0.in_ready), 32'd0);
    check("rst_inready_u1", 32'(b1.in_ready), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_inready", 32'(b0.in_ready), 32'd1);
    check("post_rst_valid", 32'(b0.out_valid), 32'd0);

    for (int i = 0; i < NV; i++) begin
      run_vec(i);
    end

    // Two-word request under back-pressure; inputs change after acceptance.
    b0.out_ready = 1'b0;
    b1.out_ready = 1'b0;
    drive_req(1'b0, 32'h1234_5678, 5'd8);
    b0.in_value = 32'hDEAD_BEEF;
    b0.in_rt    = 5'd31;
    for (int c = 0; c < 3; c++) begin
      sample(1'b0, v, ins, e, l, r);
      check($sformatf("stall%0d_valid", c), 32'(v), 32'd1);
      check($sformatf("stall%0d_instr", c), ins, 32'h3C08_1234);
      check($sformatf("stall%0d_eop", c), 32'(e), 32'd2);
      check($sformatf("stall%0d_last", c), 32'(l), 32'd0);
      check($sformatf("stall%0d_inready", c), 32'(r), 32'd0);
      @(posedge clk);
      #1;
    end
    b0.out_ready = 1'b1;
    @(posedge clk);
    #1;
    sample(1'b0, v, ins, e, l, r);
    check("stall_w2_valid", 32'(v), 32'd1);
    check("stall_w2_instr", ins, 32'h3508_5678);
    check("stall_w2_last", 32'(l), 32'd1);
    check("stall_w2_inready", 32'(r), 32'd0);
    @(posedge clk);
    #1;
    sample(1'b0, v, ins, e, l, r);
    check("stall_done_valid", 32'(v), 32'd0);
    check("stall_done_inready", 32'(r), 32'd1);

    // Reset between the two words of a lui+ori pair.
    b0.out_ready = 1'b0;
    drive_req(1'b0, 32'h1234_5678, 5'd8);
    check("mid_w1_instr", b0.out_instr, 32'h3C08_1234);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(b0.out_valid), 32'd0);
    check("mid_rst_instr", b0.out_instr, 32'd0);
    check("mid_rst_inready", 32'(b0.in_ready), 32'd0);
`ifdef IMM_ENC_STATS_EN
    check("mid_rst_stat_words", 32'(sw0), 32'd0);
    check("mid_rst_stat_pairs", 32'(sp0), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    b0.out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("mid_after%0d_valid", c), 32'(b0.out_valid), 32'd0);
      check($sformatf("mid_after%0d_inready", c), 32'(b0.in_ready), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety net so the bench always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/imm_enc.md
IMM_ENC -- requirements
Module: imm_enc

Interface
REQ-001 SHALL have parameter USE_ADDIU, default 1, meaning 1 = sign-extend (addiu) encoding allowed, 0 = only ori/lui encodings.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  a constant-load request is presented.
REQ-005 SHALL have port in_ready  output  1  request accepted when in_valid && in_ready at a clock edge.
REQ-006 SHALL have port in_value  input  32  constant to be loaded.
REQ-007 SHALL have port in_rt  input  5  destination register number.
REQ-008 SHALL have port out_valid  output  1  out_instr holds a valid MIPS instruction word.
REQ-009 SHALL have port out_ready  input  1  consumer takes the word when out_valid && out_ready.
REQ-010 SHALL have port out_instr  output  32  emitted instruction word.
REQ-011 SHALL have port out_eop  output  2  extender mode the decode side applies to out_instr[15:0] (00 sign, 01 zero, 10 upper).
REQ-012 SHALL have port out_last  output  1  current word is the final word for the request.

Function
REQ-013 SHALL classify each accepted value with this priority: (a) USE_ADDIU=1 and in_value[31:15] all equal -> one word, addiu rt,$0,imm, out_eop=00; (b) in_value[31:16]==0 -> one word, ori rt,$0,imm, out_eop=01; (c) in_value[15:0]==0 -> one word, lui rt,hi, out_eop=10; (d) otherwise -> two words, lui rt,hi then ori rt,rt,lo.
REQ-014 SHALL use opcodes addiu 6'b001001, ori 6'b001101, lui 6'b001111, with fields {op,rs,rt,imm16}; rs=0 except for the second ori of case (d), where rs=rt.
REQ-015 SHALL never emit out_eop=11.
REQ-016 SHALL implement FSM IDLE -> WORD1 on accept; WORD1 -> IDLE on handshake if single-word, else WORD1 -> WORD2; WORD2 -> IDLE on handshake.
REQ-017 SHALL drive in_ready=1 only in IDLE, so at most one request is in flight.
REQ-018 SHALL present the first word with out_valid=1 in the cycle after acceptance (latency 1).
REQ-019 SHALL hold out_instr, out_eop and out_last stable while out_valid && !out_ready.
REQ-020 SHALL drive out_last=1 on the single word of cases (a)-(c) and on the second word of case (d) only.
REQ-021 SHALL treat in_rt=0 like any other register and emit the words unchanged.
REQ-022 SHALL register in_value and in_rt at acceptance; later changes on these inputs have no effect on words already in flight.

Reset
REQ-023 SHALL, while rst_n=0, force state IDLE, out_valid=0, out_instr=0, out_eop=00, out_last=0 and in_ready=0, regardless of clk.
REQ-024 SHALL drive in_ready=1 in the first cycle after rst_n deasserts.
REQ-025 SHALL discard any pending word, including the second word of case (d), on reset mid-operation.

Configuration
REQ-026 SHALL, with macro IMM_ENC_STATS_EN defined, add output ports stat_words[15:0] and stat_pairs[15:0], counting completed output handshakes and completed case (d) requests. Both counters SHALL reset to 0, wrap modulo 2^16 and count only at handshake edges.
REQ-027 SHALL, without IMM_ENC_STATS_EN, omit both ports and counters and leave all other behaviour identical.

Verification
REQ-028 SHALL cover: in_value=0xFFFFFFFF, rt=8, USE_ADDIU=1 -> one word 0x2408FFFF, out_eop=00, out_last=1.
REQ-029 SHALL cover: in_value=0x00008000, rt=9 -> one word 0x34098000, out_eop=01 (boundary: not sign-representable).
REQ-030 SHALL cover: in_value=0x12340000, rt=10 -> one word 0x3C0A1234, out_eop=10.
REQ-031 SHALL cover: in_value=0x12345678, rt=8, out_ready low for 3 cycles -> 0x3C081234 held stable (out_last=0), then 0x35085678 (out_last=1), with in_ready=0 throughout.
REQ-032 SHALL cover: USE_ADDIU=0, in_value=0xFFFFFFFF, rt=8 -> 0x3C08FFFF then 0x3508FFFF.
REQ-033 SHALL cover: rst_n pulsed low between word 1 and word 2 of case (d) -> out_valid=0 immediately and no second word; with IMM_ENC_STATS_EN, both stats read 0 after reset.
